uart_tx_arbiter: RTL

- Shares a single UART transmitter byte interface among NUM_REQUESTERS byte-stream sources, for example CPU debug print, boot-status reporter and a hardware trace tap.
- Sits between the requesters and the rvx_ocelot UART transmit byte port.
- Grants are round-robin and message-locked: a granted requester owns the UART until it sends a byte flagged last, so messages never interleave.

---
 rtl/uart_tx_arbiter_pkg.sv | 6 +
 rtl/uart_tx_arbiter_rr_priority_picker.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared types and constants for the UART TX arbiter.
package uart_tx_arbiter_pkg;
    typedef enum logic {IDLE, LOCKED} state_e;
    localparam int GRANT_ID_WIDTH = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 65535;
endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// rr_priority_picker: picks the first set request scanning upward from ptr_i+1, with wrap-around.
module rr_priority_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] c;
    // Scan lowest priority first so the highest-priority hit overwrites earlier ones.
    always_comb begin
        grant_o = '0;
        idx_o = '0;
        c = '0;
        for (int i = N; i >= 1; i--) begin
            c = IW'((int'(ptr_i) + i) % N);
            if (req_i[c]) begin
                grant_o = '0;
                grant_o[c] = 1'b1;
                idx_o = c;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked sharing of one UART TX byte port.
// Define UART_TX_ARBITER_TIMEOUT_EN to force-release a lock after TIMEOUT_CYCLES idle cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_REQUESTERS-1:0]            req_valid,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQUESTERS-1:0]            req_last,
    output logic [NUM_REQUESTERS-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]                uart_tx_data,
    output logic                                 uart_tx_valid,
    input  logic                                 uart_tx_ready,
    output logic                                 grant_active,
    output logic [GRANT_ID_WIDTH-1:0]            grant_id
);
    localparam int IW = $clog2(NUM_REQUESTERS);
    state_e state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, gid_q, gid_d, win_idx;
    logic [NUM_REQUESTERS-1:0] win_onehot;
    logic locked, xfer, release_lock, expire;

    rr_priority_picker #(.N(NUM_REQUESTERS)) u_pick (
        .req_i  (req_valid),
        .ptr_i  (rr_ptr_q),
        .grant_o(win_onehot),
        .idx_o  (win_idx)
    );

    assign locked = state_q == LOCKED;
    assign grant_active = locked;
    assign grant_id = locked ? GRANT_ID_WIDTH'(gid_q) : '0;
    assign uart_tx_valid = locked & req_valid[gid_q];
    assign uart_tx_data = locked ? req_data[gid_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign req_ready = locked ? NUM_REQUESTERS'(uart_tx_ready) << gid_q : '0;
    assign xfer = uart_tx_valid & uart_tx_ready;
    assign release_lock = (xfer & req_last[gid_q]) | expire;

    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        gid_d = gid_q;
        if (!locked && |win_onehot) begin
            state_d = LOCKED;
            gid_d = win_idx;
        end else if (locked && release_lock) begin
            state_d = IDLE;
            rr_ptr_d = gid_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_ptr_q <= IW'(NUM_REQUESTERS - 1);
            gid_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q <= gid_d;
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic [15:0] idle_cnt_q, idle_cnt_d;
    // Expire on the idle cycle that brings the count to TIMEOUT_CYCLES.
    assign expire = locked & ~req_valid[gid_q] & (idle_cnt_q >= 16'(TIMEOUT_CYCLES - 1));
    assign idle_cnt_d = (!locked || xfer) ? '0
                      : (!req_valid[gid_q] && idle_cnt_q != '1) ? idle_cnt_q + 16'd1
                      : idle_cnt_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) idle_cnt_q <= '0;
        else idle_cnt_q <= idle_cnt_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign expire = 1'b0;
`endif
endmodule
